hazard_ctl: RTL and testbench
=============================

Name: hazard_ctl

Overview:
Pipeline hazard controller for the 5-stage MIPS core, replacing the empty hazard stub and driving the global stall/flush controls that fetch/decode/execute/memory currently see tied to 0. It produces EX operand forwarding selects, detects load-use hazards, sequences multi-cycle EX ops (mult/div) with a counter FSM, and flushes wrong-path instructions on taken branches and jumps.

Parameters:
MC_LAT, 4, total EX-occupancy cycles of a multi-cycle op (>=1); stall length = MC_LAT-1
CNT_W, 32, width of optional performance counters

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low (0 = reset asserted)
Rs_ID  in  5  decode source reg A
Rt_ID  in  5  decode source reg B
UsesRs_ID  in  1  ID instr reads Rs
UsesRt_ID  in  1  ID instr reads Rt
Jump_ID  in  1  jump resolved in ID
Rs_EX  in  5  EX source reg A
Rt_EX  in  5  EX source reg B
WriteReg_EX  in  5  EX destination
RegWrite_EX  in  1  EX writes RF
MemToReg_EX  in  1  EX instr is a load
MultiCycStart_EX  in  1  pulse: multi-cycle op entered EX this cycle
BranchTaken_EX  in  1  branch resolved taken in EX
WriteReg_ME  in  5  ME destination
RegWrite_ME  in  1  ME writes RF
WriteReg_WB  in  5  WB destination
RegWrite_WB  in  1  WB writes RF
Stall_IF  out  1  hold PC
Stall_ID  out  1  hold IF/ID
Stall_EX  out  1  hold ID/EX and EX op
Flush_ID  out  1  bubble into IF/ID
Flush_EX  out  1  bubble into ID/EX
Flush_ME  out  1  bubble into EX/ME
FwdA_EX  out  2  operand A select
FwdB_EX  out  2  operand B select
AnyStall  out  1  Stall_IF | Stall_ID | Stall_EX
Busy  out  1  FSM in MCBUSY

Behaviour:
- FSM states RUN, MCBUSY; reset -> RUN, counter 0; all outputs 0 while reset low and in RUN with no hazards.
- Forwarding (combinational, per operand): 2'b10 if RegWrite_ME && WriteReg_ME!=0 && WriteReg_ME==src_EX; else 2'b01 if RegWrite_WB && WriteReg_WB!=0 && match; else 2'b00. ME beats WB.
- Load-use (combinational, RUN only): RegWrite_EX && MemToReg_EX && WriteReg_EX!=0 && ((UsesRs_ID && Rs_ID==WriteReg_EX) || (UsesRt_ID && Rt_ID==WriteReg_EX)) -> Stall_IF=Stall_ID=Flush_EX=1 that cycle. Self-clears next cycle (load advances to ME).
- Multi-cycle: MultiCycStart_EX in RUN with MC_LAT>=2 -> Stall_IF/Stall_ID/Stall_EX/Flush_ME asserted for exactly MC_LAT-1 consecutive cycles starting in the start cycle; FSM in MCBUSY for the later MC_LAT-2 of them, counter width $clog2(MC_LAT)+1; returns to RUN when count expires. MC_LAT==1: no stall, FSM stays RUN. MultiCycStart_EX ignored while in MCBUSY.
- Branch: BranchTaken_EX -> Flush_ID=Flush_EX=1, overrides load-use (no stall that cycle). Not sampled in MCBUSY.
- Jump: Jump_ID && !Stall_ID -> Flush_ID=1. If load-use stalls the same cycle, jump flush is deferred (jump retained in ID).
- Priority: reset > MCBUSY stall > BranchTaken_EX > load-use > jump.
- Reset asserted mid-MCBUSY: immediate return to RUN, stalls drop asynchronously.

Optional Feature:
HAZARD_PERF_CNT_EN: defined -> adds outputs StallCnt[CNT_W-1:0] (+1 each cycle AnyStall=1) and FlushCnt[CNT_W-1:0] (+1 each cycle Flush_ID|Flush_EX), wrapping, cleared by reset. Undefined -> ports and counters absent; behaviour otherwise identical.

Decomposition:
Shared package mips_pkg: FSM state enum (RUN, MCBUSY), forwarding encodings FWD_RF=2'b00, FWD_WB=2'b01, FWD_ME=2'b10. One sub-module hazard_mc_timer (load/decrement/expire counter, async active-low reset) instantiated by hazard_ctl.

Test Plan:
- MemToReg_EX=1, RegWrite_EX=1, WriteReg_EX=2, UsesRs_ID=1, Rs_ID=2 -> Stall_IF=Stall_ID=Flush_EX=1 for exactly 1 cycle; same with WriteReg_EX=0 -> no stall.
- RegWrite_ME=1 WriteReg_ME=5, RegWrite_WB=1 WriteReg_WB=5, Rs_EX=5 -> FwdA_EX=2'b10; drop RegWrite_ME -> 2'b01; Rs_EX=0 with ME dest 0 -> 2'b00.
- MC_LAT=4, MultiCycStart_EX pulse -> Stall_EX/Stall_IF/Stall_ID/Flush_ME high exactly 3 cycles, Busy high 2 cycles, then RUN; second pulse during MCBUSY ignored.
- BranchTaken_EX=1 concurrent with load-use condition -> Flush_ID=Flush_EX=1, Stall_IF=0.
- Jump_ID=1 during load-use stall -> Flush_ID=0 that cycle, Flush_ID=1 next cycle.
- reset driven 0 in the 2nd stall cycle of an MC_LAT=4 op -> all stalls 0 immediately; after release a new start gives the full 3-cycle stall.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types for the MIPS pipeline hazard logic: hazard FSM states and EX
// operand forwarding selects.
package mips_pkg;

   typedef enum logic [0:0] {
      StRun    = 1'b0,
      StMcBusy = 1'b1
   } hz_state_e;

   localparam logic [1:0] FWD_RF = 2'b00;
   localparam logic [1:0] FWD_WB = 2'b01;
   localparam logic [1:0] FWD_ME = 2'b10;

   // The younger producer in ME holds the newest value, so it wins over WB.
   function automatic logic [1:0] fwd_sel(input logic       rw_me,
                                          input logic [4:0] wr_me,
                                          input logic       rw_wb,
                                          input logic [4:0] wr_wb,
                                          input logic [4:0] src);
      if (rw_me && (wr_me != 5'd0) && (wr_me == src)) begin
         return FWD_ME;
      end else if (rw_wb && (wr_wb != 5'd0) && (wr_wb == src)) begin
         return FWD_WB;
      end
      return FWD_RF;
   endfunction

endpackage

// File: rtl/hazard_mc_timer.sv
// Down-counter sequencing the busy phase of a multi-cycle EX op; expire_o
// flags the last busy cycle.
module hazard_mc_timer #(
   parameter int unsigned Width = 3
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             load_i,
   input  logic [Width-1:0] load_val_i,
   input  logic             dec_i,
   output logic             expire_o
);

   logic [Width-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_val_i;
      end else if (dec_i && (count_q != '0)) begin
         count_d = count_q - Width'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign expire_o = (count_q == Width'(1));

endmodule

// File: rtl/hazard_ctl.sv
// Pipeline hazard controller: forwarding selects, load-use stall, multi-cycle EX
// sequencing and branch/jump flushes. HAZARD_PERF_CNT_EN adds stall/flush counters.
module hazard_ctl
   import mips_pkg::*;
#(
   parameter int unsigned MC_LAT = 4
`ifdef HAZARD_PERF_CNT_EN
   ,
   parameter int unsigned CNT_W  = 32
`endif
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] Rs_ID,
   input  logic [4:0] Rt_ID,
   input  logic       UsesRs_ID,
   input  logic       UsesRt_ID,
   input  logic       Jump_ID,
   input  logic [4:0] Rs_EX,
   input  logic [4:0] Rt_EX,
   input  logic [4:0] WriteReg_EX,
   input  logic       RegWrite_EX,
   input  logic       MemToReg_EX,
   input  logic       MultiCycStart_EX,
   input  logic       BranchTaken_EX,
   input  logic [4:0] WriteReg_ME,
   input  logic       RegWrite_ME,
   input  logic [4:0] WriteReg_WB,
   input  logic       RegWrite_WB,
   output logic       Stall_IF,
   output logic       Stall_ID,
   output logic       Stall_EX,
   output logic       Flush_ID,
   output logic       Flush_EX,
   output logic       Flush_ME,
   output logic [1:0] FwdA_EX,
   output logic [1:0] FwdB_EX,
   output logic       AnyStall,
`ifdef HAZARD_PERF_CNT_EN
   output logic [CNT_W-1:0] StallCnt,
   output logic [CNT_W-1:0] FlushCnt,
`endif
   output logic       Busy
);

   localparam int unsigned CntW      = $clog2(MC_LAT) + 1;
   localparam bit          McStalls  = (MC_LAT >= 2);
   localparam bit          EnterBusy = (MC_LAT >= 3);
   localparam logic [CntW-1:0] BusyLen = CntW'(EnterBusy ? MC_LAT - 2 : 0);

   hz_state_e state_q, state_d;
   logic      timer_load, timer_dec, timer_expire;
   logic      load_use;
   logic      stall_if, stall_id, stall_ex, flush_id, flush_ex, flush_me;

   hazard_mc_timer #(
      .Width (CntW)
   ) u_mc_timer (
      .clk_i      (clk),
      .rst_ni     (reset),
      .load_i     (timer_load),
      .load_val_i (BusyLen),
      .dec_i      (timer_dec),
      .expire_o   (timer_expire)
   );

   assign load_use = RegWrite_EX && MemToReg_EX && (WriteReg_EX != 5'd0) &&
                     ((UsesRs_ID && (Rs_ID == WriteReg_EX)) ||
                      (UsesRt_ID && (Rt_ID == WriteReg_EX)));

   always_comb begin
      state_d    = state_q;
      timer_load = 1'b0;
      timer_dec  = 1'b0;
      stall_if   = 1'b0;
      stall_id   = 1'b0;
      stall_ex   = 1'b0;
      flush_id   = 1'b0;
      flush_ex   = 1'b0;
      flush_me   = 1'b0;
      unique case (state_q)
         StMcBusy: begin
            // Branch and start inputs are not sampled while the op occupies EX.
            {stall_if, stall_id, stall_ex, flush_me} = 4'b1111;
            timer_dec = 1'b1;
            if (timer_expire) begin
               state_d = StRun;
            end
         end
         StRun: begin
            if (MultiCycStart_EX && McStalls) begin
               {stall_if, stall_id, stall_ex, flush_me} = 4'b1111;
               if (EnterBusy) begin
                  state_d    = StMcBusy;
                  timer_load = 1'b1;
               end
            end else if (BranchTaken_EX) begin
               flush_id = 1'b1;
               flush_ex = 1'b1;
            end else if (load_use) begin
               // A jump in ID stays put and gets flushed once the stall clears.
               stall_if = 1'b1;
               stall_id = 1'b1;
               flush_ex = 1'b1;
            end else if (Jump_ID) begin
               flush_id = 1'b1;
            end
         end
         default: state_d = StRun;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StRun;
      end else begin
         state_q <= state_d;
      end
   end

   assign Stall_IF = reset & stall_if;
   assign Stall_ID = reset & stall_id;
   assign Stall_EX = reset & stall_ex;
   assign Flush_ID = reset & flush_id;
   assign Flush_EX = reset & flush_ex;
   assign Flush_ME = reset & flush_me;
   assign AnyStall = Stall_IF | Stall_ID | Stall_EX;
   assign Busy     = reset & (state_q == StMcBusy);
   assign FwdA_EX  = reset ? fwd_sel(RegWrite_ME, WriteReg_ME, RegWrite_WB, WriteReg_WB, Rs_EX)
                           : FWD_RF;
   assign FwdB_EX  = reset ? fwd_sel(RegWrite_ME, WriteReg_ME, RegWrite_WB, WriteReg_WB, Rt_EX)
                           : FWD_RF;

`ifdef HAZARD_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (AnyStall) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         end
         if (Flush_ID | Flush_EX) begin
            flush_cnt_q <= flush_cnt_q + CNT_W'(1);
         end
      end
   end

   assign StallCnt = stall_cnt_q;
   assign FlushCnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctl.sv
// Directed bench for hazard_ctl (MC_LAT=4) with an expected-value scoreboard.
module tb_hazard_ctl;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] Rs_ID, Rt_ID, Rs_EX, Rt_EX, WriteReg_EX, WriteReg_ME, WriteReg_WB;
   logic       UsesRs_ID, UsesRt_ID, Jump_ID, RegWrite_EX, MemToReg_EX;
   logic       MultiCycStart_EX, BranchTaken_EX, RegWrite_ME, RegWrite_WB;
   logic       Stall_IF, Stall_ID, Stall_EX, Flush_ID, Flush_EX, Flush_ME;
   logic [1:0] FwdA_EX, FwdB_EX;
   logic       AnyStall, Busy;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [11:0] v;
      string       tag;
   } exp_t;

   exp_t sb[$];

   hazard_ctl #(.MC_LAT(4)) dut (
      .clk              (clk),
      .reset            (reset),
      .Rs_ID            (Rs_ID),
      .Rt_ID            (Rt_ID),
      .UsesRs_ID        (UsesRs_ID),
      .UsesRt_ID        (UsesRt_ID),
      .Jump_ID          (Jump_ID),
      .Rs_EX            (Rs_EX),
      .Rt_EX            (Rt_EX),
      .WriteReg_EX      (WriteReg_EX),
      .RegWrite_EX      (RegWrite_EX),
      .MemToReg_EX      (MemToReg_EX),
      .MultiCycStart_EX (MultiCycStart_EX),
      .BranchTaken_EX   (BranchTaken_EX),
      .WriteReg_ME      (WriteReg_ME),
      .RegWrite_ME      (RegWrite_ME),
      .WriteReg_WB      (WriteReg_WB),
      .RegWrite_WB      (RegWrite_WB),
      .Stall_IF         (Stall_IF),
      .Stall_ID         (Stall_ID),
      .Stall_EX         (Stall_EX),
      .Flush_ID         (Flush_ID),
      .Flush_EX         (Flush_EX),
      .Flush_ME         (Flush_ME),
      .FwdA_EX          (FwdA_EX),
      .FwdB_EX          (FwdB_EX),
      .AnyStall         (AnyStall),
      .Busy             (Busy)
   );

   always #5 clk = ~clk;

   wire [11:0] obs = {Stall_IF, Stall_ID, Stall_EX, Flush_ID, Flush_EX, Flush_ME,
                      FwdA_EX, FwdB_EX, Busy, AnyStall};

   function automatic logic [11:0] ev(input logic si, input logic sid, input logic sex,
                                      input logic fid, input logic fex, input logic fme,
                                      input logic [1:0] fa, input logic [1:0] fb,
                                      input logic busy);
      return {si, sid, sex, fid, fex, fme, fa, fb, busy, si | sid | sex};
   endfunction

   task automatic push(input logic [11:0] v, input string tag);
      exp_t e;
      e.v   = v;
      e.tag = tag;
      sb.push_back(e);
   endtask

   task automatic pop_check();
      exp_t e;
      if (sb.size() == 0) begin
         failures++;
         $error("FAIL scoreboard_empty observed=%b", obs);
      end else begin
         e = sb.pop_front();
         checks++;
         assert (obs === e.v) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", e.tag, obs, e.v);
         end
      end
   endtask

   task automatic step(input logic [11:0] v, input string tag);
      push(v, tag);
      @(negedge clk);
      pop_check();
   endtask

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      {Rs_ID, Rt_ID, Rs_EX, Rt_EX, WriteReg_EX, WriteReg_ME, WriteReg_WB} = '0;
      {UsesRs_ID, UsesRt_ID, Jump_ID, RegWrite_EX, MemToReg_EX} = '0;
      {MultiCycStart_EX, BranchTaken_EX, RegWrite_ME, RegWrite_WB} = '0;
   endtask

   task automatic load_use_2();
      RegWrite_EX = 1'b1; MemToReg_EX = 1'b1; WriteReg_EX = 5'd2;
      UsesRs_ID   = 1'b1; Rs_ID       = 5'd2;
   endtask

   localparam logic [11:0] Zero = 12'b0;

   initial begin
      logic [11:0] mc_start_v, mc_busy_v, lu_v;
      mc_start_v = ev(1, 1, 1, 0, 0, 1, 2'b00, 2'b00, 0);
      mc_busy_v  = ev(1, 1, 1, 0, 0, 1, 2'b00, 2'b00, 1);
      lu_v       = ev(1, 1, 0, 0, 1, 0, 2'b00, 2'b00, 0);

      reset = 1'b0;
      clr();
      RegWrite_ME = 1'b1; WriteReg_ME = 5'd5; Rs_EX = 5'd5;
      load_use_2();
      step(Zero, "reset_low");

      next(); reset = 1'b1; clr();
      step(Zero, "idle");

      // Load-use on Rs: one stall cycle, gone once the load leaves EX.
      next(); load_use_2();
      step(lu_v, "lu_rs");
      next(); clr();
      step(Zero, "lu_rs_cleared");
      next(); load_use_2(); WriteReg_EX = 5'd0; Rs_ID = 5'd0;
      step(Zero, "lu_dest_zero");
      next(); clr();
      RegWrite_EX = 1'b1; MemToReg_EX = 1'b1; WriteReg_EX = 5'd7; UsesRt_ID = 1'b1; Rt_ID = 5'd7;
      step(lu_v, "lu_rt");
      next(); UsesRt_ID = 1'b0;
      step(Zero, "lu_rt_unused");
      next(); UsesRt_ID = 1'b1; MemToReg_EX = 1'b0;
      step(Zero, "lu_not_load");

      // Forwarding priority and register-0 exclusion.
      next(); clr();
      RegWrite_ME = 1'b1; WriteReg_ME = 5'd5; RegWrite_WB = 1'b1; WriteReg_WB = 5'd5;
      Rs_EX = 5'd5;
      step(ev(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 0), "fwd_me_wins");
      next(); RegWrite_ME = 1'b0;
      step(ev(0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 0), "fwd_wb");
      next(); RegWrite_ME = 1'b1; WriteReg_ME = 5'd0; WriteReg_WB = 5'd0; Rs_EX = 5'd0;
      step(Zero, "fwd_reg0");
      next(); WriteReg_ME = 5'd5; Rs_EX = 5'd5; WriteReg_WB = 5'd9; Rt_EX = 5'd9;
      step(ev(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 0), "fwd_both_ops");

      // Multi-cycle op: 3 stall cycles, 2 of them busy; restart and branch ignored.
      next(); clr(); MultiCycStart_EX = 1'b1;
      step(mc_start_v, "mc_c1");
      next(); MultiCycStart_EX = 1'b0; BranchTaken_EX = 1'b1;
      step(mc_busy_v, "mc_c2_branch_ignored");
      next(); BranchTaken_EX = 1'b0; MultiCycStart_EX = 1'b1;
      step(mc_busy_v, "mc_c3_restart_ignored");
      next(); MultiCycStart_EX = 1'b0;
      step(Zero, "mc_done");
      next();
      step(Zero, "mc_stays_run");

      // Taken branch overrides load-use.
      next(); load_use_2(); BranchTaken_EX = 1'b1;
      step(ev(0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 0), "branch_over_lu");

      // Jump deferred by load-use stall, flushed the following cycle.
      next(); clr(); load_use_2(); Jump_ID = 1'b1;
      step(lu_v, "jump_deferred");
      next(); RegWrite_EX = 1'b0; MemToReg_EX = 1'b0;
      step(ev(0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 0), "jump_flush");

      // Reset in the second stall cycle drops everything immediately.
      next(); clr(); MultiCycStart_EX = 1'b1;
      step(mc_start_v, "rst_mc_c1");
      next(); MultiCycStart_EX = 1'b0;
      step(mc_busy_v, "rst_mc_c2");
      reset = 1'b0;
      push(Zero, "rst_async_drop");
      #1;
      pop_check();
      next(); reset = 1'b1;
      step(Zero, "rst_released");
      next(); MultiCycStart_EX = 1'b1;
      step(mc_start_v, "post_rst_c1");
      next(); MultiCycStart_EX = 1'b0;
      step(mc_busy_v, "post_rst_c2");
      next();
      step(mc_busy_v, "post_rst_c3");
      next();
      step(Zero, "post_rst_done");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      failures++;
      $display("FAIL timeout checks=%0d", checks);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
